// File: rtl/key_chunk_tx.sv
// key_chunk_tx: sends a KEY_WIDTH-bit key as KEY_WIDTH/CHUNK words, LSB word
// first, each qualified by a one-cycle load_key strobe. Strobes are spaced by
// GAP idle cycles, and done pulses on the cycle after the final strobe.
// Optional feature: define KEYTX_CHECKSUM_EN to append one extra word equal
// to the XOR of all data words. That word is the one flagged by last.
module key_chunk_tx #(
  parameter int KEY_WIDTH = 16,
  parameter int CHUNK     = 4,
  parameter int GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic                 busy,
  output logic                 load_key,
  output logic [CHUNK-1:0]     key_data,
  output logic                 last,
  output logic                 done
);

  localparam int N = KEY_WIDTH / CHUNK;
`ifdef KEYTX_CHECKSUM_EN
  localparam int M = N + 1;
`else
  localparam int M = N;
`endif
  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

  state_t               state, state_nx;
  logic [KEY_WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [3:0]           gap_cnt, gap_nx;
  logic [CHUNK-1:0]     word_nx;
`ifdef KEYTX_CHECKSUM_EN
  localparam logic [CW-1:0] DATA_END = CW'(N);
  logic [CHUNK-1:0]     csum, csum_nx;
`endif

  // Next-state, shift/count updates and the word to present on the next strobe
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    gap_nx   = gap_cnt;
`ifdef KEYTX_CHECKSUM_EN
    csum_nx  = csum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEND;
          sr_nx    = key_in;
          cnt_nx   = '0;
          gap_nx   = '0;
`ifdef KEYTX_CHECKSUM_EN
          csum_nx  = '0;
`endif
        end
      end
      SEND: begin
        sr_nx  = sr >> CHUNK;
        cnt_nx = cnt + CW'(1);
        gap_nx = '0;
`ifdef KEYTX_CHECKSUM_EN
        if (cnt < DATA_END) csum_nx = csum ^ sr[CHUNK-1:0];
`endif
        if (cnt == LAST_IDX) state_nx = FIN;
        else if (GAP > 0)    state_nx = WAIT;
        else                 state_nx = SEND;
      end
      WAIT: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = SEND;
          gap_nx   = '0;
        end else begin
          gap_nx   = gap_cnt + 4'd1;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    word_nx = sr_nx[CHUNK-1:0];
`ifdef KEYTX_CHECKSUM_EN
    // Once every data word has been consumed the next word is the checksum
    if (cnt_nx == DATA_END) word_nx = csum_nx;
`endif
  end

  // State/datapath registers; outputs registered from the next state so the
  // first strobe lands in the cycle right after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
`ifdef KEYTX_CHECKSUM_EN
      csum     <= '0;
`endif
      busy     <= 1'b0;
      load_key <= 1'b0;
      key_data <= '0;
      last     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      cnt      <= cnt_nx;
      gap_cnt  <= gap_nx;
`ifdef KEYTX_CHECKSUM_EN
      csum     <= csum_nx;
`endif
      busy     <= (state_nx != IDLE);
      load_key <= (state_nx == SEND);
      key_data <= (state_nx == SEND) ? word_nx : '0;
      last     <= (state_nx == SEND) && (cnt_nx == LAST_IDX);
      done     <= (state_nx == FIN);
    end
  end

endmodule

// File: tb/tb_key_chunk_tx.sv
// Bench for key_chunk_tx: three instances (16b/GAP1, 16b/GAP0, 8b/GAP1)
// share start/key/reset. A reference model derives every output from the
// cycle offset since acceptance; literal word tables pin the model.
module tb_key_chunk_tx;

  localparam int ND = 3;
`ifdef KEYTX_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] key_in;
  logic        busy_w [ND];
  logic        load_w [ND];
  logic        last_w [ND];
  logic        done_w [ND];
  logic [3:0]  data_w [ND];

  key_chunk_tx #(.KEY_WIDTH(16), .CHUNK(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy_w[0]), .load_key(load_w[0]), .key_data(data_w[0]),
    .last(last_w[0]), .done(done_w[0]));

  key_chunk_tx #(.KEY_WIDTH(16), .CHUNK(4), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy_w[1]), .load_key(load_w[1]), .key_data(data_w[1]),
    .last(last_w[1]), .done(done_w[1]));

  key_chunk_tx #(.KEY_WIDTH(8), .CHUNK(4), .GAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in[7:0]),
    .busy(busy_w[2]), .load_key(load_w[2]), .key_data(data_w[2]),
    .last(last_w[2]), .done(done_w[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  function automatic int kw(input int i);
    return (i == 2) ? 8 : 16;
  endfunction
  function automatic int gp(input int i);
    return (i == 1) ? 0 : 1;
  endfunction
  function automatic int mm(input int i);
    return kw(i) / 4 + (CS ? 1 : 0);
  endfunction
  function automatic int done_off(input int i);
    return 2 + (mm(i) - 1) * (gp(i) + 1);
  endfunction
  function automatic int xor_all(input int k, input int n);
    int w = 0;
    for (int j = 0; j < n; j++) w = w ^ ((k >> (4 * j)) & 15);
    return w;
  endfunction

  // Reference model: idle flag, offset (cycles since acceptance), captured key
  bit m_idle [ND] = '{1'b1, 1'b1, 1'b1};
  int m_off  [ND];
  int m_key  [ND];

  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (!rst_n) m_idle[i] = 1'b1;
      else if (m_idle[i]) begin
        if (start) begin
          m_idle[i] = 1'b0;
          m_off[i]  = 1;
          m_key[i]  = int'(key_in) & ((1 << kw(i)) - 1);
        end
      end else begin
        m_off[i]++;
        if (m_off[i] > done_off(i)) m_idle[i] = 1'b1;
      end
    end
  end

  // {busy, load_key, last, done, key_data}
  function automatic logic [7:0] exp_vec(input int i);
    int d, p, k, w;
    logic b, l, la, dn;
    if (m_idle[i]) return 8'h00;
    d  = m_off[i];
    p  = gp(i) + 1;
    b  = 1'b1;
    dn = (d == done_off(i));
    l  = 1'b0; la = 1'b0; w = 0;
    if (d <= 1 + (mm(i) - 1) * p && ((d - 1) % p) == 0) begin
      k  = (d - 1) / p;
      l  = 1'b1;
      la = (k == mm(i) - 1);
      w  = (k < kw(i) / 4) ? ((m_key[i] >> (4 * k)) & 15) : xor_all(m_key[i], kw(i) / 4);
    end
    return {b, l, la, dn, 4'(w)};
  endfunction

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
  endtask

  // Event log for the literal trace checks
  int ev_cyc [ND][32];
  int ev_dat [ND][32];
  bit ev_last[ND][32];
  int ev_n [ND];
  int done_n [ND];
  int done_cyc [ND];
  int busy_n [ND];

  // Compare every instance against the model each cycle, and log events
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < ND; i++) begin
        lit($sformatf("model.dut%0d", i),
            {24'd0, busy_w[i], load_w[i], last_w[i], done_w[i], data_w[i]},
            {24'd0, exp_vec(i)});
        if (load_w[i] === 1'b1) begin
          if (ev_n[i] < 32) begin
            ev_cyc[i][ev_n[i]]  = cyc;
            ev_dat[i][ev_n[i]]  = int'(data_w[i]);
            ev_last[i][ev_n[i]] = last_w[i];
          end
          ev_n[i]++;
        end
        if (done_w[i] === 1'b1) begin
          if (done_n[i] == 0) done_cyc[i] = cyc;
          done_n[i]++;
        end
        if (busy_w[i] === 1'b1) busy_n[i]++;
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < ND; i++) begin
      ev_n[i] = 0; done_n[i] = 0; busy_n[i] = 0; done_cyc[i] = -1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] k, output int t0);
    clear_logs();
    start  = 1'b1;
    key_in = k;
    t0     = cyc;
    step(1);
    start  = 1'b0;
  endtask

  // words: nibble k holds the literal expected word k
  task automatic check_trace(input int i, input int t0, input int words, input string nm);
    int p = gp(i) + 1;
    lit($sformatf("%s.d%0d.count", nm, i), ev_n[i], mm(i));
    for (int k = 0; k < mm(i); k++) begin
      lit($sformatf("%s.d%0d.cyc%0d", nm, i, k), ev_cyc[i][k], t0 + 1 + k * p);
      lit($sformatf("%s.d%0d.word%0d", nm, i, k), ev_dat[i][k], (words >> (4 * k)) & 15);
      lit($sformatf("%s.d%0d.last%0d", nm, i, k), {31'd0, ev_last[i][k]}, (k == mm(i) - 1) ? 1 : 0);
    end
    lit($sformatf("%s.d%0d.done_n", nm, i), done_n[i], 1);
    lit($sformatf("%s.d%0d.done_cyc", nm, i), done_cyc[i], t0 + done_off(i));
    lit($sformatf("%s.d%0d.busy_n", nm, i), busy_n[i], done_off(i));
  endtask

  task automatic basic_1234(input string nm);
    int t0;
    pulse(16'h1234, t0);
    step(20);
    check_trace(0, t0, CS ? 32'h41234 : 32'h1234, nm);
    check_trace(1, t0, CS ? 32'h41234 : 32'h1234, nm);
    check_trace(2, t0, CS ? 32'h734 : 32'h34, nm);
  endtask

  initial begin
    int t0;
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = 16'h0;
    clear_logs();
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(2);
    @(negedge clk);
    for (int i = 0; i < ND; i++)
      lit($sformatf("reset.d%0d", i),
          {27'd0, busy_w[i], load_w[i], last_w[i], done_w[i], (data_w[i] != 4'd0)}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    // Basic transfer
    basic_1234("basic");

    // Alternate pattern, exercising GAP=0 pacing on instance b
    pulse(16'hA5C3, t0);
    step(20);
    check_trace(0, t0, CS ? 32'h0A5C3 : 32'hA5C3, "a5c3");
    check_trace(1, t0, CS ? 32'h0A5C3 : 32'hA5C3, "a5c3");
    check_trace(2, t0, CS ? 32'hFC3 : 32'hC3, "a5c3");

    // start during a transfer is ignored
    pulse(16'h1234, t0);
    step(2);
    start = 1'b1; key_in = 16'hFFFF;
    step(1);
    start = 1'b0;
    step(20);
    check_trace(0, t0, CS ? 32'h41234 : 32'h1234, "ignore");
    check_trace(1, t0, CS ? 32'h41234 : 32'h1234, "ignore");
    check_trace(2, t0, CS ? 32'h734 : 32'h34, "ignore");

    // Reset in cycle 4 aborts the transfer
    pulse(16'h1234, t0);
    step(3);
    rst_n = 1'b0;
    step(1);
    @(negedge clk);
    lit("rstmid.outs",
        {27'd0, busy_w[0], load_w[0], last_w[0], done_w[0], (data_w[0] != 4'd0)}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(10);
    lit("rstmid.count", ev_n[0], 2);
    lit("rstmid.word0", ev_dat[0][0], 4);
    lit("rstmid.word1", ev_dat[0][1], 3);
    lit("rstmid.done_n", done_n[0], 0);
    basic_1234("after_rst");

    // Continuous start: re-acceptance right after the IDLE cycle
    clear_logs();
    start = 1'b1; key_in = 16'h009E; t0 = cyc;
    step(24);
    start = 1'b0;
    step(12);
    lit("cont.first_cyc", ev_cyc[2][0], t0 + 1);
    lit("cont.word0", ev_dat[2][0], 32'hE);
    lit("cont.word1", ev_dat[2][1], 32'h9);
    lit("cont.word2", ev_dat[2][2], CS ? 32'h7 : 32'hE);
    lit("cont.restart_gap", ev_cyc[2][mm(2)] - done_cyc[2], 2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      start  = ($urandom_range(0, 2) == 0);
      key_in = 16'($urandom);
      rst_n  = ($urandom_range(0, 63) != 0);
      step(1);
    end
    rst_n = 1'b1;
    start = 1'b0;
    step(30);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/key_chunk_tx.md
# key_chunk_tx

Key provisioning transmitter for the locked design's key-load port. It accepts a full-width key over a start handshake and emits it as a sequence of CHUNK-bit words, each qualified by a one-cycle `load_key` strobe. Words are paced with a programmable idle gap, which makes the block the driving end of the `load_key`/`key_data` interface. It sits between on-chip key storage or a test controller and the key register of the locked core.

## Interface
- `KEY_WIDTH`, default 16: total key bits. Must be a positive multiple of `CHUNK`.
- `CHUNK`, default 4: bits per transferred word. Equals the locked core's key-port width.
- `GAP`, default 1: idle cycles between consecutive strobes. Range 0..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request to transmit. Sampled only in IDLE.
- `key_in`  in  KEY_WIDTH  key to send. Captured on the accepted `start` cycle.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `load_key`  out  1  one-cycle strobe; `key_data` is valid while it is high.
- `key_data`  out  CHUNK  current word. Held at 0 when `load_key` is low.
- `last`  out  1  high together with `load_key` on the final word only.
- `done`  out  1  one-cycle pulse, the cycle after the final strobe.

## Operation
- N = KEY_WIDTH/CHUNK data words. Word i = `key_in[i*CHUNK +: CHUNK]`. Words go out LSB-first (i = 0 .. N-1).
- States:
  - IDLE: `start`=1 captures `key_in` into a shift register, clears the word counter, and moves to SEND.
  - SEND: asserts `load_key` with the current word for exactly one cycle. Shifts the register right by CHUNK and increments the counter. If that was the final word, moves to FIN. Otherwise moves to WAIT when GAP>0, or stays in SEND when GAP=0.
  - WAIT: counts GAP cycles, then returns to SEND.
  - FIN: pulses `done`, then returns to IDLE.
- `start` outside IDLE is ignored. It is neither queued nor able to restart the transfer.
- `key_in` changes after acceptance have no effect.
- `start` held high continuously: a new transfer is accepted in the IDLE cycle that follows FIN.
- Reset values: `busy`, `load_key`, `key_data`, `last` and `done` are all 0. State is IDLE, the counters are 0 and the shift register is 0.
- A reset asserted mid-transfer aborts it at the next edge. No further strobes and no `done` follow.
- Counter widths: word counter holds 0..N (N+1 with checksum). Gap counter is 4 bits. Neither counter wraps within a transfer.

## Timing
- Acceptance edge = cycle 0.
- First strobe in cycle 1. Strobe k (0-based) falls in cycle 1 + k*(GAP+1).
- Final strobe in cycle 1 + (M-1)*(GAP+1), where M is the total word count.
- `done` follows one cycle after the final strobe. IDLE is re-entered on the cycle after that, so earliest re-acceptance is `done` cycle + 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `KEYTX_CHECKSUM_EN` defined:
  - After the N data words, one extra word is sent, equal to the XOR of all N data words. M = N+1.
  - `last` marks the checksum word, and the same pacing rules apply.
- `KEYTX_CHECKSUM_EN` undefined:
  - M = N, and `last` marks data word N-1.
  - No XOR logic is present.

## Test plan
- Basic transfer (defaults, macro off). `key_in`=0x1234, `start` in cycle 0 → strobes with `key_data` 4,3,2,1 in cycles 1,3,5,7. `last` is high in cycle 7 only, `done` in cycle 8, `busy` high in cycles 1..8.
- Back-to-back pacing (GAP=0). `key_in`=0xA5C3 → words 3,C,5,A in cycles 1..4 consecutively, `done` in cycle 5.
- Checksum (macro on, defaults). `key_in`=0x1234 → words 4,3,2,1,4 in cycles 1,3,5,7,9. `last` is high in cycle 9, `done` in cycle 10.
- Ignored start. Pulse `start` with `key_in`=0xFFFF in cycle 3 of a 0x1234 transfer → output sequence unchanged (4,3,2,1), and `busy` drops after the single `done`.
- Reset mid-operation. Assert `rst_n`=0 in cycle 4 of a 0x1234 transfer → all outputs 0 from cycle 5, and there is no strobe for words 2 and 1. A fresh `start` after release produces the full sequence again.
- Continuous `start` plus width check (`KEY_WIDTH`=8, `CHUNK`=4). `key_in`=0x9E → words E,9, then `done`. The second transfer's first strobe comes 2 cycles after `done`.
